// File: rtl/trace_pkg.sv
// Shared definitions for the retired-instruction trace buffer: FSM state
// codes, trace-entry field widths and the packing layout of one entry.
package trace_pkg;

    // FSM state codes; the numeric values are visible on the state port
    localparam logic [1:0] TR_IDLE  = 2'd0;
    localparam logic [1:0] TR_ARMED = 2'd1;
    localparam logic [1:0] TR_POST  = 2'd2;
    localparam logic [1:0] TR_DONE  = 2'd3;

    // Fixed field widths of a trace entry
    localparam int unsigned TR_INSTR_W      = 32;
    localparam int unsigned TR_OP_W         = 16;
    localparam int unsigned TR_SEL_W        = 5;
    localparam int unsigned TR_XLEN_DEFAULT = 32;

    // Entry width for a given XLEN: {instr, full_op_code, rd_sel, rd_data}
    function automatic int unsigned tr_entry_w(input int unsigned xlen);
        return TR_INSTR_W + TR_OP_W + TR_SEL_W + xlen;
    endfunction

    localparam int unsigned TR_ENTRY_W = tr_entry_w(TR_XLEN_DEFAULT);

    // Field offsets inside a packed entry; rd_data occupies the LSBs
    function automatic int unsigned tr_sel_off(input int unsigned xlen);
        return xlen;
    endfunction

    function automatic int unsigned tr_op_off(input int unsigned xlen);
        return xlen + TR_SEL_W;
    endfunction

    function automatic int unsigned tr_instr_off(input int unsigned xlen);
        return xlen + TR_SEL_W + TR_OP_W;
    endfunction

endpackage

// File: rtl/trace_mem.sv
// DEPTH x W register file: one synchronous write port, one asynchronous
// read port. No reset; contents are only read after being written.
module trace_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 85
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Capture one entry per enabled write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero-latency read for the readout port
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/instr_trace_buffer.sv
// Retired-instruction trace capture: circular buffer of DEPTH entries,
// opcode-match / forced trigger, POST_TRIG post-trigger entries, then
// oldest-first replay over a valid/ready port.
module instr_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tr_valid,
    input  logic [31:0]            instr,
    input  logic [15:0]            full_op_code,
    input  logic [4:0]             rd_sel,
    input  logic [XLEN-1:0]        rd_data,
    input  logic                   arm,
    input  logic [15:0]            trig_op,
    input  logic [15:0]            trig_mask,
    input  logic                   trig_force,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [31:0]            out_instr,
    output logic [15:0]            out_op,
    output logic [4:0]             out_rd_sel,
    output logic [XLEN-1:0]        out_rd_data,
    output logic [1:0]             state,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned EW        = tr_entry_w(XLEN);
    localparam int unsigned SEL_OFF   = tr_sel_off(XLEN);
    localparam int unsigned OP_OFF    = tr_op_off(XLEN);
    localparam int unsigned INSTR_OFF = tr_instr_off(XLEN);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PC_FULL  = AW'(POST_TRIG);
    localparam logic [AW-1:0] PC_LESS1 = AW'(POST_TRIG - 1);
    localparam logic [AW-1:0] PC_ONE   = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] wr_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          wr_en;
    logic          trig;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;

    // Trigger compare and write enable; arm always suppresses the write
    always_comb begin
        trig  = (tr_valid && (((full_op_code ^ trig_op) & trig_mask) == '0)) || trig_force;
        wr_en = 1'b0;
        if (!arm && tr_valid) begin
            if (state == TR_ARMED) begin
                wr_en = 1'b1;
            end else if (state == TR_POST && post_cnt != '0) begin
                wr_en = 1'b1;
            end
        end
        wr_ptr_nxt = wr_ptr + 1'b1;
        count_nxt  = (count == CNT_FULL) ? count : count + 1'b1;
        wdata      = {instr, full_op_code, rd_sel, rd_data};
    end

    trace_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // FSM, pointers and counters; arm clears are placed after the write
    // update so they take priority within the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TR_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            post_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr_nxt;
                count  <= count_nxt;
                if (count == CNT_FULL) begin
                    overflow <= 1'b1;
                end
            end
            case (state)
                TR_IDLE: begin
                    if (arm) begin
                        state    <= TR_ARMED;
                        wr_ptr   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                TR_ARMED: begin
                    if (arm) begin
                        wr_ptr   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end else if (trig) begin
                        state    <= TR_POST;
                        post_cnt <= tr_valid ? PC_LESS1 : PC_FULL;
                    end
                end
                TR_POST: begin
                    if (arm) begin
                        state    <= TR_ARMED;
                        wr_ptr   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end else if (post_cnt == '0) begin
                        state  <= TR_DONE;
                        rd_ptr <= wr_ptr - count[AW-1:0];
                    end else if (tr_valid) begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == PC_ONE) begin
                            // Oldest entry computed from the post-write pointer/count
                            state  <= TR_DONE;
                            rd_ptr <= wr_ptr_nxt - count_nxt[AW-1:0];
                        end
                    end
                end
                default: begin
                    if (count == '0) begin
                        state <= TR_IDLE;
                    end else if (out_ready) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        count  <= count - 1'b1;
                        if (count == CNT_ONE) begin
                            state <= TR_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Readout port; fields forced to zero whenever nothing is offered
    always_comb begin
        out_valid   = (state == TR_DONE) && (count != '0);
        out_instr   = out_valid ? rdata[INSTR_OFF +: TR_INSTR_W] : '0;
        out_op      = out_valid ? rdata[OP_OFF +: TR_OP_W]       : '0;
        out_rd_sel  = out_valid ? rdata[SEL_OFF +: TR_SEL_W]     : '0;
        out_rd_data = out_valid ? rdata[XLEN-1:0]                : '0;
    end

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Self-checking bench for instr_trace_buffer (XLEN=32, DEPTH=16, POST_TRIG=4).
module tb_instr_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tr_valid;
    logic [31:0] instr;
    logic [15:0] full_op_code;
    logic [4:0]  rd_sel;
    logic [31:0] rd_data;
    logic        arm;
    logic [15:0] trig_op;
    logic [15:0] trig_mask;
    logic        trig_force;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [15:0] out_op;
    logic [4:0]  out_rd_sel;
    logic [31:0] out_rd_data;
    logic [1:0]  state;
    logic [4:0]  count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    logic [84:0] model[$];

    typedef struct {
        logic [15:0] op;
        logic [15:0] tmask;
        logic [15:0] top;
        logic        force_trig;
        logic [1:0]  exp_state;
        logic [4:0]  exp_count;
    } trig_vec_t;

    trig_vec_t vecs[6];

    instr_trace_buffer #(
        .XLEN      (32),
        .DEPTH     (16),
        .POST_TRIG (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tr_valid     (tr_valid),
        .instr        (instr),
        .full_op_code (full_op_code),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data),
        .arm          (arm),
        .trig_op      (trig_op),
        .trig_mask    (trig_mask),
        .trig_force   (trig_force),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_op       (out_op),
        .out_rd_sel   (out_rd_sel),
        .out_rd_data  (out_rd_data),
        .state        (state),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [84:0] ent(input int k, input logic [15:0] op);
        logic [31:0] kv;
        kv = k;
        return {32'h1000_0000 + kv, op, kv[4:0], 32'hA5A5_0000 ^ (kv * 32'd977)};
    endfunction

    function automatic logic [84:0] dut_ent();
        return {out_instr, out_op, out_rd_sel, out_rd_data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
        model.delete();
    endtask

    // Drive one retired instruction; captured entries go to the scoreboard
    task automatic wr(input int k, input logic [15:0] op, input bit capture);
        logic [84:0] e;
        e            = ent(k, op);
        tr_valid     = 1'b1;
        instr        = e[84:53];
        full_op_code = e[52:37];
        rd_sel       = e[36:32];
        rd_data      = e[31:0];
        step();
        tr_valid     = 1'b0;
        if (capture) begin
            model.push_back(e);
            if (model.size() > 16) void'(model.pop_front());
        end
    endtask

    task automatic force_trig();
        trig_force = 1'b1;
        step();
        trig_force = 1'b0;
    endtask

    // Pop everything with out_ready high, comparing against the scoreboard
    task automatic drain(input string nm);
        int budget;
        budget    = 64;
        out_ready = 1'b1;
        while (model.size() > 0 && budget > 0) begin
            if (out_valid) begin
                check({nm, " entry"}, dut_ent(), model.pop_front());
            end
            step();
            budget--;
        end
        out_ready = 1'b0;
        if (model.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got %0d entries left expected 0", nm, model.size());
        end
        check({nm, " end state"}, state, 2'd0);
        check({nm, " end valid"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [84:0] snap;

        rst = 1'b1; tr_valid = 1'b0; instr = '0; full_op_code = '0; rd_sel = '0;
        rd_data = '0; arm = 1'b0; trig_op = '0; trig_mask = '0; trig_force = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{16'h0013, 16'h0000, 16'h0063, 1'b0, 2'd2, 5'd1};
        vecs[1] = '{16'h0013, 16'hFFFF, 16'h0063, 1'b0, 2'd1, 5'd1};
        vecs[2] = '{16'h1263, 16'h007F, 16'h0063, 1'b0, 2'd2, 5'd1};
        vecs[3] = '{16'h0063, 16'hFFFF, 16'h1063, 1'b0, 2'd1, 5'd1};
        vecs[4] = '{16'h0013, 16'hFFFF, 16'h0063, 1'b1, 2'd2, 5'd1};
        vecs[5] = '{16'hABCD, 16'hF0F0, 16'hA0C0, 1'b0, 2'd2, 5'd1};

        step();
        step();
        rst = 1'b0;
        check("reset state", state, 2'd0);
        check("reset count", count, 5'd0);
        check("reset overflow", overflow, 1'b0);
        check("reset valid", out_valid, 1'b0);
        check("reset instr", out_instr, 32'd0);

        // Trigger compare table: one write after arm, then state/count
        for (int i = 0; i < 6; i++) begin
            pulse_arm();
            trig_mask  = vecs[i].tmask;
            trig_op    = vecs[i].top;
            trig_force = vecs[i].force_trig;
            wr(100 + i, vecs[i].op, 1'b0);
            trig_force = 1'b0;
            check($sformatf("vec%0d state", i), state, vecs[i].exp_state);
            check($sformatf("vec%0d count", i), count, vecs[i].exp_count);
        end

        // Forced trigger between writes: 3 pre + 4 post entries
        trig_mask = 16'hFFFF;
        trig_op   = 16'hFFFF;
        pulse_arm();
        for (int k = 0; k < 3; k++) wr(k, 16'h0013, 1'b1);
        force_trig();
        check("force state", state, 2'd2);
        check("force count", count, 5'd3);
        for (int k = 3; k < 7; k++) wr(k, 16'h0013, 1'b1);
        check("force done state", state, 2'd3);
        check("force done count", count, 5'd7);
        drain("force drain");

        // Wrap-around with overflow: 20 writes, match on #21, 3 more
        trig_op = 16'hBEEF;
        pulse_arm();
        for (int k = 1; k <= 20; k++) wr(k, 16'h0013, 1'b1);
        check("wrap armed", state, 2'd1);
        wr(21, 16'hBEEF, 1'b1);
        for (int k = 22; k <= 24; k++) wr(k, 16'h0013, 1'b1);
        check("wrap state", state, 2'd3);
        check("wrap count", count, 5'd16);
        check("wrap overflow", overflow, 1'b1);
        check("wrap first", dut_ent(), ent(9, 16'h0013));
        drain("wrap drain");

        // Branch trigger at #5, sequence ends at #8, then stalled readout
        trig_mask = 16'h007F;
        trig_op   = 16'h0063;
        pulse_arm();
        for (int k = 1; k <= 8; k++) begin
            wr(200 + k, (k == 5) ? 16'h0063 : 16'h0013, 1'b1);
            if (k == 4) check("branch pre", state, 2'd1);
            if (k == 7) check("branch post", state, 2'd2);
        end
        check("branch state", state, 2'd3);
        check("branch count", count, 5'd8);
        check("branch overflow", overflow, 1'b0);
        out_ready = 1'b1;
        check("stall pop1", dut_ent(), model.pop_front());
        step();
        out_ready = 1'b0;
        snap = model[0];
        check("stall hold0", dut_ent(), snap);
        step();
        check("stall hold1", dut_ent(), snap);
        check("stall valid", out_valid, 1'b1);
        step();
        check("stall hold2", dut_ent(), snap);
        out_ready = 1'b1;
        void'(model.pop_front());
        step();
        out_ready = 1'b0;
        check("stall count", count, 5'd6);
        check("stall next", dut_ent(), model[0]);
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("done arm state", state, 2'd3);
        check("done arm count", count, 5'd6);
        drain("branch drain");

        // arm during POST clears count and overflow
        trig_mask = 16'hFFFF;
        trig_op   = 16'hFFFF;
        pulse_arm();
        for (int k = 0; k < 17; k++) wr(300 + k, 16'h0013, 1'b0);
        check("post ovf set", overflow, 1'b1);
        force_trig();
        wr(400, 16'h0013, 1'b0);
        check("post state", state, 2'd2);
        pulse_arm();
        check("rearm state", state, 2'd1);
        check("rearm count", count, 5'd0);
        check("rearm overflow", overflow, 1'b0);

        // Reset mid-POST
        wr(401, 16'h0013, 1'b0);
        force_trig();
        wr(402, 16'h0013, 1'b0);
        check("pre rst state", state, 2'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst state", state, 2'd0);
        check("rst count", count, 5'd0);
        check("rst overflow", overflow, 1'b0);
        check("rst valid", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
